// File: rtl/gpio_apb_port.sv
// APB switch/LED peripheral: synchronised switch inputs with change-detect status, W1C clear and maskable irq.
// Define GPIO_APB_SW_DEBOUNCE_EN to insert the switch debounce filter.
module gpio_apb_port #(
  parameter int                   SW_WIDTH        = 32,
  parameter int                   LED_WIDTH       = 32,
  parameter int                   SYNC_STAGES     = 2,
  parameter int                   DEBOUNCE_CYCLES = 4,
  parameter logic [LED_WIDTH-1:0] LED_RESET       = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [3:0]           paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  input  logic [SW_WIDTH-1:0]  SW,
  output logic [LED_WIDTH-1:0] LED,
  output logic                 irq
);

  localparam logic [1:0] ADDR_SW_IN  = 2'd0;
  localparam logic [1:0] ADDR_LED    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_MASK   = 2'd3;

  logic [SW_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [SW_WIDTH-1:0]  sw_sync;
  logic [SW_WIDTH-1:0]  sw_stable_q, sw_stable_d;
  logic [SW_WIDTH-1:0]  status_q, status_d;
  logic [SW_WIDTH-1:0]  mask_q, mask_d;
  logic [SW_WIDTH-1:0]  w1c;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          prdata_q, prdata_d, rd_data;
  logic                 pready_q, pready_d;
  logic                 irq_q, irq_d;
  logic                 wr_en;
  logic                 unused_ok;

  // Low address bits and pwdata bits beyond the register widths carry no meaning.
  assign unused_ok = ^{paddr[1:0], pwdata};

  // NOTE: every element of the synchroniser array is reset explicitly; a reset loop over an
  // unpacked array is fine here because these are plain flops, not a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_APB_SW_DEBOUNCE_EN
  localparam int                CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    sw_stable_d = sw_stable_q;
    if (sw_sync != cand_q) begin
      cand_d = sw_sync;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) sw_stable_d = cand_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign sw_stable_d = sw_sync;
`endif

  always_comb begin
    rd_data = '0;
    case (paddr[3:2])
      ADDR_SW_IN:  rd_data = 32'(sw_stable_q);
      ADDR_LED:    rd_data = 32'(led_q);
      ADDR_STATUS: rd_data = 32'(status_q);
      ADDR_MASK:   rd_data = 32'(mask_q);
    endcase
  end

  // pready_q doubles as "a setup phase preceded this access", so orphan access phases write nothing.
  assign wr_en    = psel & penable & pwrite & pready_q;
  assign pready_d = psel & ~penable;
  assign prdata_d = (psel & ~penable & ~pwrite) ? rd_data : '0;
  assign irq_d    = |(status_q & mask_q);

  always_comb begin
    led_d  = led_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en) begin
      case (paddr[3:2])
        ADDR_LED:    led_d  = pwdata[LED_WIDTH-1:0];
        ADDR_STATUS: w1c    = pwdata[SW_WIDTH-1:0];
        ADDR_MASK:   mask_d = pwdata[SW_WIDTH-1:0];
        default:     ;
      endcase
    end
    // A new change on a bit being cleared this cycle keeps the bit set.
    status_d = (status_q & ~w1c) | (sw_stable_d ^ sw_stable_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_stable_q <= '0;
      status_q    <= '0;
      mask_q      <= '0;
      led_q       <= LED_RESET;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sw_stable_q <= sw_stable_d;
      status_q    <= status_d;
      mask_q      <= mask_d;
      led_q       <= led_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      irq_q       <= irq_d;
    end
  end

  assign prdata = prdata_q;
  assign pready = pready_q;
  assign LED    = led_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_apb_port.sv
// Directed self-checking bench for gpio_apb_port: register table plus switch, irq and reset sequences.
// Expectations follow GPIO_APB_SW_DEBOUNCE_EN when it is defined for the build.
module tb_gpio_apb_port;

`ifdef GPIO_APB_SW_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  localparam logic [3:0] A_SW = 4'h0, A_LED = 4'h4, A_STATUS = 4'h8, A_MASK = 4'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic [31:0] SW;
  logic [31:0] LED;
  logic        irq;

  int total = 0;
  int bad   = 0;

  gpio_apb_port dut (
    .clk     (clk),
    .reset   (reset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .SW      (SW),
    .LED     (LED),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    check("wr_pready_access", {31'b0, pready}, 32'd1);
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    check("rd_pready_access", {31'b0, pready}, 32'd1);
    d = prdata;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check("rd_idle_pready_prdata", {prdata[30:0], pready}, 32'd0);
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    apb_read(a, rd);
    check(name, rd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    vecs.push_back('{1'b0, A_SW,     32'h0000_0000});
    vecs.push_back('{1'b0, A_LED,    32'h0000_0000});
    vecs.push_back('{1'b0, A_STATUS, 32'h0000_0000});
    vecs.push_back('{1'b0, A_MASK,   32'h0000_0000});
    vecs.push_back('{1'b1, A_LED,    32'hA5A5_1234});
    vecs.push_back('{1'b0, A_LED,    32'hA5A5_1234});
    vecs.push_back('{1'b1, A_SW,     32'hDEAD_BEEF});
    vecs.push_back('{1'b0, A_SW,     32'h0000_0000});
    vecs.push_back('{1'b1, A_MASK,   32'h1234_8001});
    vecs.push_back('{1'b0, A_MASK,   32'h1234_8001});
    vecs.push_back('{1'b1, A_STATUS, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, A_STATUS, 32'h0000_0000});
    vecs.push_back('{1'b1, 4'h7,     32'h0000_0F0F});
    vecs.push_back('{1'b0, A_LED,    32'h0000_0F0F});
    vecs.push_back('{1'b1, A_LED,    32'hA5A5_1234});
    vecs.push_back('{1'b0, 4'h5,     32'hA5A5_1234});

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; SW = '0;
    #150;
    check("rst_led", LED, 32'h0);
    check("rst_pready_irq", {30'b0, pready, irq}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    #150;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data);
        if (vecs[i].addr[3:2] == 2'd1) check($sformatf("vec%0d_led_pin", i), LED, vecs[i].data);
      end else begin
        apb_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_read", i), rd, vecs[i].data);
      end
    end
    check("table_irq_quiet", {31'b0, irq}, 32'd0);

    // Switch latency, measured through irq with every bit unmasked.
    apb_write(A_MASK, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    SW = 32'h3;
    repeat (LAT) @(posedge clk);
    #1 check("lat_irq_not_yet", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("lat_irq_set", {31'b0, irq}, 32'd1);
    read_check("lat_sw_in", A_SW, 32'h3);
    read_check("lat_status", A_STATUS, 32'h3);
    apb_write(A_STATUS, 32'h3);
    @(posedge clk); #1;
    check("w1c_irq_clear", {31'b0, irq}, 32'd0);
    read_check("w1c_status", A_STATUS, 32'h0);

    // Falling edges are changes too.
    SW = 32'h0;
    repeat (LAT + 2) @(posedge clk);
    #1 read_check("fall_status", A_STATUS, 32'h3);
    read_check("fall_sw_in", A_SW, 32'h0);
    apb_write(A_STATUS, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Two-cycle glitch on bit0.
    SW = 32'h1;
    repeat (2) @(posedge clk);
    #1 SW = 32'h0;
    repeat (LAT + 4) @(posedge clk);
    #1;
`ifdef GPIO_APB_SW_DEBOUNCE_EN
    check("glitch_irq", {31'b0, irq}, 32'd0);
    read_check("glitch_status", A_STATUS, 32'h0);
`else
    check("glitch_irq", {31'b0, irq}, 32'd1);
    read_check("glitch_status", A_STATUS, 32'h1);
    apb_write(A_STATUS, 32'h1);
    @(posedge clk); #1;
`endif
    read_check("glitch_sw_in", A_SW, 32'h0);

    // Masked interrupt.
    apb_write(A_MASK, 32'h1);
    SW = 32'h2;
    repeat (LAT + 2) @(posedge clk);
    #1 check("masked_irq", {31'b0, irq}, 32'd0);
    read_check("masked_status", A_STATUS, 32'h2);
    apb_write(A_STATUS, 32'h2);
    SW = 32'h3;
    repeat (LAT + 2) @(posedge clk);
    #1 check("bit0_irq", {31'b0, irq}, 32'd1);
    apb_write(A_STATUS, 32'h1);
    @(posedge clk); #1;
    check("bit0_w1c_irq", {31'b0, irq}, 32'd0);

    // Bit0 falls, then rises again exactly on the edge that commits its W1C.
    SW = 32'h2;
    repeat (LAT + 2) @(posedge clk);
    #1 check("pre_collide_irq", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    SW = 32'h3;
    repeat (LAT - 3) @(posedge clk);
    apb_write(A_STATUS, 32'h1);
    @(posedge clk); #1;
    check("collide_irq", {31'b0, irq}, 32'd1);
    read_check("collide_status", A_STATUS, 32'h1);

    // Access phase with no setup phase must be ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = A_LED; pwdata = 32'h1111_1111;
    @(posedge clk); #1;
    check("orphan_pready", {31'b0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    check("orphan_led", LED, 32'hA5A5_1234);

    // Asynchronous reset in the access phase of a LED write.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_LED; pwdata = 32'h0000_00FF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 reset = 1'b1;
    #1 check("arst_led", LED, 32'h0);
    check("arst_pready_irq", {30'b0, pready, irq}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("arst_led_after", LED, 32'h0);
    check("arst_irq_after", {31'b0, irq}, 32'd0);
    read_check("arst_led_reg", A_LED, 32'h0);
    read_check("arst_mask_reg", A_MASK, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
